io_handshake_ctrl: RTL and testbench

//  Sequences the processor's IN/OUT/HALT instructions against the board I/O.

---
 rtl/io_handshake_ctrl_if.sv | 26 ++
 rtl/io_handshake_ctrl.sv | 128 ++++++++++++
 tb/tb_io_handshake_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/io_handshake_ctrl_if.sv
// Handshake bundle between ControlUnit/board I/O and the IN/OUT/HALT sequencer.
// The master modport drives the instruction flags and board inputs; the slave modport is the controller.
interface io_handshake_ctrl_if;
  logic        input_flag;
  logic        output_flag;
  logic        halt;
  logic        insert;
  logic [14:0] SW;
  logic [31:0] out_data;
  logic        pc_stall;
  logic [31:0] user_input;
  logic [31:0] display_value;
  logic        display_valid;
  logic        halted;
  logic [2:0]  state_dbg;

  modport master (
    output input_flag, output_flag, halt, insert, SW, out_data,
    input  pc_stall, user_input, display_value, display_valid, halted, state_dbg
  );

  modport slave (
    input  input_flag, output_flag, halt, insert, SW, out_data,
    output pc_stall, user_input, display_value, display_valid, halted, state_dbg
  );
endinterface

// File: rtl/io_handshake_ctrl.sv
// Sequences IN/OUT/HALT instructions against the board I/O: stalls the PC for a
// debounced insert press/release on IN, a fixed hold on OUT, and forever on HALT.
//
// state      | meaning
// IDLE       | waiting for an IN/OUT/HALT instruction
// IN_PRESS   | IN pending, waiting for a debounced insert press
// IN_RELEASE | SW latched, waiting for a debounced insert release
// OUT_HOLD   | OUT data latched, holding the PC for the programmed time
// DONE       | one unstalled cycle so the PC moves past the instruction
// HALTED     | core frozen until reset
module io_handshake_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OUT_HOLD_CYCLES = 2,
  parameter bit SIGN_EXT        = 1'b0
) (
  input  logic                CLK,
  input  logic                reset,
  io_handshake_ctrl_if.slave  io
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > OUT_HOLD_CYCLES) ? DEBOUNCE_CYCLES : OUT_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OH_LAST = CNT_W'(OUT_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IN_PRESS   = 3'd1,
    IN_RELEASE = 3'd2,
    OUT_HOLD   = 3'd3,
    DONE       = 3'd4,
    HALTED     = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      user_input_q;
  logic [31:0]      display_value_q;
  logic             display_valid_q;
  logic [16:0]      sw_ext;

  assign sw_ext = (SIGN_EXT && io.SW[14]) ? 17'h1FFFF : 17'h00000;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      user_input_q    <= '0;
      display_value_q <= '0;
      display_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (io.halt) begin
            state <= HALTED;
          end else if (io.input_flag) begin
            state <= IN_PRESS;
          end else if (io.output_flag) begin
            state           <= OUT_HOLD;
            display_value_q <= io.out_data;
            display_valid_q <= 1'b1;
          end
        end
        IN_PRESS: begin
          if (!io.insert) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            cnt          <= '0;
            user_input_q <= {sw_ext, io.SW};
            state        <= IN_RELEASE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IN_RELEASE: begin
          // A held key keeps resetting the count, so the core stays stalled.
          if (io.insert) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        OUT_HOLD: begin
          if (cnt == OH_LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        HALTED: begin
          cnt <= '0;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    io.pc_stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:                                  io.pc_stall = io.halt | io.input_flag | io.output_flag;
        IN_PRESS, IN_RELEASE, OUT_HOLD, HALTED: io.pc_stall = 1'b1;
        default:                               io.pc_stall = 1'b0;
      endcase
    end
  end

  assign io.user_input    = user_input_q;
  assign io.display_value = display_value_q;
  assign io.display_valid = display_valid_q;
  assign io.halted        = (state == HALTED);
  assign io.state_dbg     = state;

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Self-checking bench for io_handshake_ctrl: a zero-extending and a sign-extending
// instance share stimulus; each row's expected outputs are queued and checked mid-cycle.
module tb_io_handshake_ctrl;

  typedef struct {
    logic        rst;
    logic        inf;
    logic        outf;
    logic        hlt;
    logic        ins;
    logic [14:0] sw;
    logic [31:0] od;
    logic        e_stall;
    logic [2:0]  e_state;
    logic [31:0] e_user;
    logic [31:0] e_user_sx;
    logic [31:0] e_disp;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  logic CLK = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  vec_t exp_q[$];
  vec_t tbl[18];

  always #5 CLK = ~CLK;

  io_handshake_ctrl_if bus();
  io_handshake_ctrl_if bus_sx();

  assign bus_sx.input_flag  = bus.input_flag;
  assign bus_sx.output_flag = bus.output_flag;
  assign bus_sx.halt        = bus.halt;
  assign bus_sx.insert      = bus.insert;
  assign bus_sx.SW          = bus.SW;
  assign bus_sx.out_data    = bus.out_data;

  io_handshake_ctrl dut (
    .CLK   (CLK),
    .reset (reset),
    .io    (bus)
  );

  io_handshake_ctrl #(.SIGN_EXT(1'b1)) dut_sx (
    .CLK   (CLK),
    .reset (reset),
    .io    (bus_sx)
  );

  function automatic vec_t mk(logic rst, logic inf, logic outf, logic hlt, logic ins,
                              logic [14:0] sw, logic [31:0] od, logic e_stall,
                              logic [2:0] e_state, logic [31:0] e_user, logic [31:0] e_user_sx,
                              logic [31:0] e_disp, logic e_valid, logic e_halted);
    vec_t v;
    v.rst = rst; v.inf = inf; v.outf = outf; v.hlt = hlt; v.ins = ins;
    v.sw = sw; v.od = od; v.e_stall = e_stall; v.e_state = e_state;
    v.e_user = e_user; v.e_user_sx = e_user_sx; v.e_disp = e_disp;
    v.e_valid = e_valid; v.e_halted = e_halted;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_one();
    vec_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got empty queue expected one entry");
      return;
    end
    e = exp_q.pop_front();
    chk("pc_stall",       32'(bus.pc_stall),       32'(e.e_stall));
    chk("state_dbg",      32'(bus.state_dbg),      32'(e.e_state));
    chk("user_input",     bus.user_input,          e.e_user);
    chk("user_input_sx",  bus_sx.user_input,       e.e_user_sx);
    chk("display_value",  bus.display_value,       e.e_disp);
    chk("display_valid",  32'(bus.display_valid),  32'(e.e_valid));
    chk("halted",         32'(bus.halted),         32'(e.e_halted));
    chk("pc_stall_sx",    32'(bus_sx.pc_stall),    32'(e.e_stall));
  endtask

  task automatic step(input vec_t v);
    @(posedge CLK);
    #1;
    reset           = v.rst;
    bus.input_flag  = v.inf;
    bus.output_flag = v.outf;
    bus.halt        = v.hlt;
    bus.insert      = v.ins;
    bus.SW          = v.sw;
    bus.out_data    = v.od;
    exp_q.push_back(v);
    @(negedge CLK);
    check_one();
  endtask

  initial begin
    reset = 1'b1;
    bus.input_flag = 1'b1; bus.output_flag = 1'b0; bus.halt = 1'b0;
    bus.insert = 1'b0; bus.SW = '0; bus.out_data = '0;
    @(posedge CLK);

    // reset with input_flag high, then a clean IN, then an OUT
    tbl[0]  = mk(1,1,0,0,0, 15'h1234, 32'h0,        0, 3'd0, 32'h0,    32'h0,    32'h0,        0, 0);
    tbl[1]  = mk(1,1,0,0,0, 15'h1234, 32'h0,        0, 3'd0, 32'h0,    32'h0,    32'h0,        0, 0);
    tbl[2]  = mk(0,1,0,0,0, 15'h1234, 32'h0,        1, 3'd0, 32'h0,    32'h0,    32'h0,        0, 0);
    tbl[3]  = mk(0,1,0,0,1, 15'h1234, 32'h0,        1, 3'd1, 32'h0,    32'h0,    32'h0,        0, 0);
    tbl[4]  = mk(0,1,0,0,1, 15'h1234, 32'h0,        1, 3'd1, 32'h0,    32'h0,    32'h0,        0, 0);
    tbl[5]  = mk(0,1,0,0,1, 15'h1234, 32'h0,        1, 3'd1, 32'h0,    32'h0,    32'h0,        0, 0);
    tbl[6]  = mk(0,1,0,0,1, 15'h1234, 32'h0,        1, 3'd1, 32'h0,    32'h0,    32'h0,        0, 0);
    tbl[7]  = mk(0,1,0,0,0, 15'h1234, 32'h0,        1, 3'd2, 32'h1234, 32'h1234, 32'h0,        0, 0);
    tbl[8]  = mk(0,1,0,0,0, 15'h1234, 32'h0,        1, 3'd2, 32'h1234, 32'h1234, 32'h0,        0, 0);
    tbl[9]  = mk(0,1,0,0,0, 15'h1234, 32'h0,        1, 3'd2, 32'h1234, 32'h1234, 32'h0,        0, 0);
    tbl[10] = mk(0,1,0,0,0, 15'h1234, 32'h0,        1, 3'd2, 32'h1234, 32'h1234, 32'h0,        0, 0);
    tbl[11] = mk(0,1,0,0,0, 15'h1234, 32'h0,        0, 3'd4, 32'h1234, 32'h1234, 32'h0,        0, 0);
    tbl[12] = mk(0,0,0,0,0, 15'h1234, 32'h0,        0, 3'd0, 32'h1234, 32'h1234, 32'h0,        0, 0);
    tbl[13] = mk(0,0,1,0,0, 15'h0,    32'hDEADBEEF, 1, 3'd0, 32'h1234, 32'h1234, 32'h0,        0, 0);
    tbl[14] = mk(0,0,1,0,0, 15'h0,    32'h11111111, 1, 3'd3, 32'h1234, 32'h1234, 32'hDEADBEEF, 1, 0);
    tbl[15] = mk(0,0,1,0,0, 15'h0,    32'h22222222, 1, 3'd3, 32'h1234, 32'h1234, 32'hDEADBEEF, 1, 0);
    tbl[16] = mk(0,0,1,0,0, 15'h0,    32'h33333333, 0, 3'd4, 32'h1234, 32'h1234, 32'hDEADBEEF, 1, 0);
    tbl[17] = mk(0,0,0,0,0, 15'h0,    32'h0,        0, 3'd0, 32'h1234, 32'h1234, 32'hDEADBEEF, 1, 0);
    for (int i = 0; i < 18; i++) step(tbl[i]);

    // bouncing press and release; SW changes after the latch must not be seen
    begin
      logic press[7]   = '{1,1,0,1,1,1,1};
      logic release_[7] = '{0,0,1,0,0,0,0};
      step(mk(0,1,0,0,0, 15'h4001, 32'h0, 1, 3'd0, 32'h1234, 32'h1234, 32'hDEADBEEF, 1, 0));
      for (int i = 0; i < 7; i++)
        step(mk(0,1,0,0,press[i], 15'h4001, 32'h0, 1, 3'd1, 32'h1234, 32'h1234, 32'hDEADBEEF, 1, 0));
      for (int i = 0; i < 7; i++)
        step(mk(0,1,0,0,release_[i], 15'h0, 32'h0, 1, 3'd2, 32'h4001, 32'hFFFFC001, 32'hDEADBEEF, 1, 0));
      step(mk(0,1,0,0,0, 15'h0, 32'h0, 0, 3'd4, 32'h4001, 32'hFFFFC001, 32'hDEADBEEF, 1, 0));
      step(mk(0,0,0,0,0, 15'h0, 32'h0, 0, 3'd0, 32'h4001, 32'hFFFFC001, 32'hDEADBEEF, 1, 0));
    end

    // all flags at once: halt wins and only reset leaves HALTED
    step(mk(0,1,1,1,0, 15'h7FFF, 32'hCAFEF00D, 1, 3'd0, 32'h4001, 32'hFFFFC001, 32'hDEADBEEF, 1, 0));
    for (int i = 0; i < 20; i++)
      step(mk(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 15'($urandom), $urandom,
              1, 3'd5, 32'h4001, 32'hFFFFC001, 32'hDEADBEEF, 1, 1));
    step(mk(1,0,0,0,0, 15'h0, 32'h0, 0, 3'd5, 32'h4001, 32'hFFFFC001, 32'hDEADBEEF, 1, 1));
    step(mk(0,0,0,0,0, 15'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0));

    // reset in the middle of IN_RELEASE, then a fresh IN needs a full debounce
    step(mk(0,1,0,0,0, 15'h0007, 32'h0, 1, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0));
    for (int i = 0; i < 4; i++)
      step(mk(0,1,0,0,1, 15'h0007, 32'h0, 1, 3'd1, 32'h0, 32'h0, 32'h0, 0, 0));
    for (int i = 0; i < 2; i++)
      step(mk(0,1,0,0,0, 15'h0007, 32'h0, 1, 3'd2, 32'h7, 32'h7, 32'h0, 0, 0));
    step(mk(1,1,0,0,0, 15'h0007, 32'h0, 0, 3'd2, 32'h7, 32'h7, 32'h0, 0, 0));
    step(mk(0,1,0,0,1, 15'h0055, 32'h0, 1, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0));
    for (int i = 0; i < 4; i++)
      step(mk(0,1,0,0,1, 15'h0055, 32'h0, 1, 3'd1, 32'h0, 32'h0, 32'h0, 0, 0));
    step(mk(0,1,0,0,0, 15'h0055, 32'h0, 1, 3'd2, 32'h55, 32'h55, 32'h0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule
